// File: rtl/sr_flag_bank.sv
`default_nettype none
// ============================================================================
// Module      : sr_flag_bank
// Description : Bank of WIDTH clocked set/reset flags with optional input
//               synchronisers, level/edge capture, a selectable conflict rule,
//               masked software clear, masked irq and a saturating rise count.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_flag_bank #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = 0,
    parameter int               CONFLICT    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             sw_clr_en,
    input  logic [WIDTH-1:0] sw_clr_mask,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             irq,
    output logic [7:0]       event_cnt
);

    localparam int RISE_W  = $clog2(WIDTH + 1);
    localparam int CNT_MAX = 255;

    logic [WIDTH-1:0]  s_sy;
    logic [WIDTH-1:0]  r_sy;
    logic [WIDTH-1:0]  es;
    logic [WIDTH-1:0]  er;
    logic [WIDTH-1:0]  er_eff;
    logic [WIDTH-1:0]  rise_vec;
    logic [RISE_W-1:0] rises;
    logic [9:0]        cnt_sum;

    logic [WIDTH-1:0]  q_q,   q_d;
    logic              irq_q, irq_d;
    logic [7:0]        event_cnt_q, event_cnt_d;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] s_sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] s_sync_d [SYNC_STAGES];
            logic [WIDTH-1:0] r_sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] r_sync_d [SYNC_STAGES];

            always_comb begin
                s_sync_d[0] = s;
                r_sync_d[0] = r;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    s_sync_d[i] = s_sync_q[i-1];
                    r_sync_d[i] = r_sync_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        s_sync_q[i] <= '0;
                        r_sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        s_sync_q[i] <= s_sync_d[i];
                        r_sync_q[i] <= r_sync_d[i];
                    end
                end
            end

            assign s_sy = s_sync_q[SYNC_STAGES-1];
            assign r_sy = r_sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s_sy = s;
            assign r_sy = r;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Capture: level pass-through or zero-latency rising-edge detect
    // ------------------------------------------------------------------
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [WIDTH-1:0] s_prev_q, s_prev_d;
            logic [WIDTH-1:0] r_prev_q, r_prev_d;

            always_comb begin
                s_prev_d = s_sy;
                r_prev_d = r_sy;
            end

            // Cleared prev flops make an input that is high across reset
            // release appear as a fresh edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_prev_q <= '0;
                    r_prev_q <= '0;
                end else begin
                    s_prev_q <= s_prev_d;
                    r_prev_q <= r_prev_d;
                end
            end

            assign es = s_sy & ~s_prev_q;
            assign er = r_sy & ~r_prev_q;
        end else begin : g_level
            assign es = s_sy;
            assign er = r_sy;
        end
    endgenerate

    // Software clear joins the hardware reset request and obeys CONFLICT.
    assign er_eff = er | (sw_clr_mask & {WIDTH{sw_clr_en}});

    // ------------------------------------------------------------------
    // Flag next state
    // ------------------------------------------------------------------
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({es[i], er_eff[i]})
                2'b10: q_d[i] = 1'b1;
                2'b01: q_d[i] = 1'b0;
                2'b11: begin
                    case (CONFLICT)
                        0:       q_d[i] = 1'b1;
                        1:       q_d[i] = 1'b0;
                        2:       q_d[i] = ~q_q[i];
                        default: q_d[i] = q_q[i];
                    endcase
                end
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rise count and irq
    // ------------------------------------------------------------------
    always_comb begin
        rise_vec = ~q_q & q_d;
        rises    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rises = rises + RISE_W'(rise_vec[i]);
        end
    end

    // Clear acts before the add so events in the clearing cycle survive.
    always_comb begin
        cnt_sum = (cnt_clr ? 10'd0 : {2'b00, event_cnt_q}) + 10'(rises);
        if (cnt_sum > 10'(CNT_MAX)) begin
            event_cnt_d = 8'hFF;
        end else begin
            event_cnt_d = cnt_sum[7:0];
        end
        irq_d = |(q_q & irq_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= RESET_VAL;
            irq_q       <= 1'b0;
            event_cnt_q <= 8'd0;
        end else begin
            q_q         <= q_d;
            irq_q       <= irq_d;
            event_cnt_q <= event_cnt_d;
        end
    end

    assign q         = q_q;
    assign qbar      = ~q_q;
    assign irq       = irq_q;
    assign event_cnt = event_cnt_q;

endmodule
`default_nettype wire
